// File: rtl/alvio_write_arbiter_if.sv
// rtl/alvio_write_arbiter_if.sv - Bus bundle between LSU/dispatch and the active-list violation RAM write arbiter
//
// Purpose: groups the violation report, allocation-clear, flush and RAM write
// signals of alvio_write_arbiter into one interface.
// Signals:
//   vioValid0_i/vioAlId0_i   violation report, source 0 (older)
//   vioValid1_i/vioAlId1_i   violation report, source 1
//   alClrValid_i/alClrId_i   allocation clear from dispatch
//   flush_i                  pipeline recovery
//   addr0wr_o/data0wr_o/we0_o  RAM write port (registered)
//   stall_o                  LSU back-pressure
//   overflow_o               sticky dropped-report flag
// Modports: master drives the requests, slave is the arbiter.

interface alvio_write_arbiter_if #(
  parameter int INDEX = 4
);
  logic             vioValid0_i;
  logic [INDEX-1:0] vioAlId0_i;
  logic             vioValid1_i;
  logic [INDEX-1:0] vioAlId1_i;
  logic             alClrValid_i;
  logic [INDEX-1:0] alClrId_i;
  logic             flush_i;
  logic [INDEX-1:0] addr0wr_o;
  logic             data0wr_o;
  logic             we0_o;
  logic             stall_o;
  logic             overflow_o;

  modport master (
    output vioValid0_i, vioAlId0_i, vioValid1_i, vioAlId1_i,
    output alClrValid_i, alClrId_i, flush_i,
    input  addr0wr_o, data0wr_o, we0_o, stall_o, overflow_o
  );

  modport slave (
    input  vioValid0_i, vioAlId0_i, vioValid1_i, vioAlId1_i,
    input  alClrValid_i, alClrId_i, flush_i,
    output addr0wr_o, data0wr_o, we0_o, stall_o, overflow_o
  );
endinterface

// File: rtl/alvio_write_arbiter.sv
// rtl/alvio_write_arbiter.sv - Serialises violation reports and allocation clears onto the AL violation RAM write port
//
// Purpose: collects up to two violation reports and one allocation clear per
// cycle, coalesces reports in a small circular queue and issues one RAM write
// per cycle (clear first, then oldest queued report, then a bypassed report).
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    alvio_write_arbiter_if.slave (reports, clears, flush, RAM write, stall, overflow)

module alvio_write_arbiter #(
  parameter int INDEX      = 4,
  parameter int QDEPTH     = 4,
  parameter int QDEPTH_LOG = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  alvio_write_arbiter_if.slave   bus
);
  localparam int CW = QDEPTH_LOG + 1;

  typedef logic [QDEPTH_LOG-1:0] ptr_t;
  typedef logic [CW-1:0]         cnt_t;
  typedef logic [INDEX-1:0]      id_t;

  logic [QDEPTH-1:0] valid_q, valid_d, valid_c;
  id_t               id_q [QDEPTH];
  id_t               id_d [QDEPTH];
  ptr_t              head_q, head_d, tail_q, tail_d;
  cnt_t              count_q, count_d;
  logic              we_q, we_d, data_q, data_d, stall_q, stall_d, ovf_q, ovf_d;
  id_t               addr_q, addr_d;

  // Modulo-QDEPTH pointer advance; works for non-power-of-two depths too.
  function automatic ptr_t wrap_add(input ptr_t ptr, input cnt_t k);
    logic [CW:0] sum;
    sum = (CW+1)'(ptr) + (CW+1)'(k);
    if (sum >= (CW+1)'(QDEPTH)) sum = sum - (CW+1)'(QDEPTH);
    return sum[QDEPTH_LOG-1:0];
  endfunction

  logic clr, flush, found, sel_q, in_q0, in_q1, acc0, acc1, byp0, byp1;
  logic enq0, enq1, ok0, ok1;
  cnt_t skip, pop_n, count_ap, free;
  ptr_t sel_idx, tail1;
  id_t  sel_id;

  always_comb begin
    clr     = bus.alClrValid_i;
    flush   = bus.flush_i;
    found   = 1'b0;
    skip    = '0;
    sel_idx = head_q;
    in_q0   = 1'b0;
    in_q1   = 1'b0;

    // A clear kills matching queued entries in the same cycle.
    for (int i = 0; i < QDEPTH; i++) begin
      valid_c[i] = valid_q[i] && !(clr && id_q[i] == bus.alClrId_i);
      if (valid_c[i] && id_q[i] == bus.vioAlId0_i) in_q0 = 1'b1;
      if (valid_c[i] && id_q[i] == bus.vioAlId1_i) in_q1 = 1'b1;
    end

    // Skip dead entries from the head to find the oldest live report.
    for (int k = 0; k < QDEPTH; k++) begin
      if (CW'(k) < count_q && !found) begin
        if (valid_c[wrap_add(head_q, CW'(k))]) begin
          found   = 1'b1;
          sel_idx = wrap_add(head_q, CW'(k));
        end else begin
          skip = skip + CW'(1);
        end
      end
    end

    sel_q  = found && !clr && !flush;
    sel_id = id_q[sel_idx];
    pop_n  = (found && !clr) ? skip + CW'(1) : skip;

    acc0 = bus.vioValid0_i && !flush && !(clr && bus.vioAlId0_i == bus.alClrId_i)
           && !in_q0 && !(sel_q && bus.vioAlId0_i == sel_id);
    acc1 = bus.vioValid1_i && !flush && !(clr && bus.vioAlId1_i == bus.alClrId_i)
           && !in_q1 && !(sel_q && bus.vioAlId1_i == sel_id)
           && !(bus.vioValid0_i && bus.vioAlId1_i == bus.vioAlId0_i);

    byp0 = !clr && !sel_q && acc0;
    byp1 = !clr && !sel_q && !acc0 && acc1;
    enq0 = acc0 && !byp0;
    enq1 = acc1 && !byp1;

    count_ap = count_q - pop_n;
    free     = CW'(QDEPTH) - count_ap;
    ok0      = enq0 && (free != '0);
    ok1      = enq1 && (free >= (ok0 ? CW'(2) : CW'(1)));

    valid_d = valid_c;
    for (int i = 0; i < QDEPTH; i++) id_d[i] = id_q[i];
    for (int k = 0; k < QDEPTH; k++) begin
      if (CW'(k) < pop_n) valid_d[wrap_add(head_q, CW'(k))] = 1'b0;
    end

    // Pops are applied before enqueues so a full queue can refill the slot it frees.
    tail1 = ok0 ? wrap_add(tail_q, CW'(1)) : tail_q;
    if (ok0) begin
      valid_d[tail_q] = 1'b1;
      id_d[tail_q]    = bus.vioAlId0_i;
    end
    if (ok1) begin
      valid_d[tail1] = 1'b1;
      id_d[tail1]    = bus.vioAlId1_i;
    end
    tail_d  = ok1 ? wrap_add(tail1, CW'(1)) : tail1;
    head_d  = wrap_add(head_q, pop_n);
    count_d = count_ap + CW'(ok0) + CW'(ok1);
    ovf_d   = ovf_q | (enq0 && !ok0) | (enq1 && !ok1);

    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (clr) begin
      we_d = 1'b1; addr_d = bus.alClrId_i; data_d = 1'b0;
    end else if (sel_q) begin
      we_d = 1'b1; addr_d = sel_id; data_d = 1'b1;
    end else if (byp0) begin
      we_d = 1'b1; addr_d = bus.vioAlId0_i; data_d = 1'b1;
    end else if (byp1) begin
      we_d = 1'b1; addr_d = bus.vioAlId1_i; data_d = 1'b1;
    end

    if (flush) begin
      valid_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end

    stall_d = (count_d >= CW'(QDEPTH - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int i = 0; i < QDEPTH; i++) id_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= 1'b0;
      stall_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < QDEPTH; i++) id_q[i] <= id_d[i];
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      stall_q <= stall_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.we0_o      = we_q;
  assign bus.addr0wr_o  = addr_q;
  assign bus.data0wr_o  = data_q;
  assign bus.stall_o    = stall_q;
  assign bus.overflow_o = ovf_q;
endmodule

// File: tb/tb_alvio_write_arbiter.sv
// tb/tb_alvio_write_arbiter.sv - Directed self-checking bench for alvio_write_arbiter

module tb_alvio_write_arbiter;
  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  alvio_write_arbiter_if #(.INDEX(4)) bus ();

  alvio_write_arbiter #(.INDEX(4), .QDEPTH(4), .QDEPTH_LOG(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [3:0] addr, input logic data);
    chk({tag, ".we"}, 32'(bus.we0_o), 32'(we));
    if (we) begin
      chk({tag, ".addr"}, 32'(bus.addr0wr_o), 32'(addr));
      chk({tag, ".data"}, 32'(bus.data0wr_o), 32'(data));
    end
  endtask

  task automatic idle();
    bus.vioValid0_i  = 1'b0; bus.vioAlId0_i = '0;
    bus.vioValid1_i  = 1'b0; bus.vioAlId1_i = '0;
    bus.alClrValid_i = 1'b0; bus.alClrId_i  = '0;
    bus.flush_i      = 1'b0;
  endtask

  task automatic drive(input logic v0, input logic [3:0] id0, input logic v1, input logic [3:0] id1,
                       input logic c, input logic [3:0] cid, input logic fl);
    bus.vioValid0_i  = v0; bus.vioAlId0_i = id0;
    bus.vioValid1_i  = v1; bus.vioAlId1_i = id1;
    bus.alClrValid_i = c;  bus.alClrId_i  = cid;
    bus.flush_i      = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    #3;
    chk("rst.we", 32'(bus.we0_o), 0);
    chk("rst.addr", 32'(bus.addr0wr_o), 0);
    chk("rst.data", 32'(bus.data0wr_o), 0);
    chk("rst.stall", 32'(bus.stall_o), 0);
    chk("rst.ovf", 32'(bus.overflow_o), 0);
    #9 reset = 1'b1;
    tick();

    // Single report, idle queue: written next cycle, then idle.
    drive(1, 4'd5, 0, 0, 0, 0, 0);
    tick(); chk_wr("t1.w", 1, 4'd5, 1);
    idle();
    tick(); chk_wr("t1.idle", 0, 0, 0);

    // Same id from both sources: one write only.
    drive(1, 4'd7, 1, 4'd7, 0, 0, 0);
    tick(); chk_wr("t2.w", 1, 4'd7, 1);
    idle();
    tick(); chk_wr("t2.idle", 0, 0, 0);
    tick(); chk_wr("t2.idle2", 0, 0, 0);

    // Clear beats reports; reports drain oldest first.
    drive(1, 4'd3, 1, 4'd9, 1, 4'd12, 0);
    tick(); chk_wr("t3.clr", 1, 4'd12, 0);
    idle();
    tick(); chk_wr("t3.s3", 1, 4'd3, 1);
    tick(); chk_wr("t3.s9", 1, 4'd9, 1);
    tick(); chk_wr("t3.idle", 0, 0, 0);

    // Queued {4,6}, then clear 4: only 6 gets set.
    drive(1, 4'd4, 1, 4'd6, 1, 4'd0, 0);
    tick(); chk_wr("t5.clr0", 1, 4'd0, 0);
    drive(0, 0, 0, 0, 1, 4'd4, 0);
    tick(); chk_wr("t5.clr4", 1, 4'd4, 0);
    idle();
    tick(); chk_wr("t5.s6", 1, 4'd6, 1);
    tick(); chk_wr("t5.idle", 0, 0, 0);

    // Three pending, then flush with a simultaneous clear.
    drive(1, 4'd1, 1, 4'd2, 1, 4'd0, 0);
    tick(); chk_wr("t5f.c0", 1, 4'd0, 0);
    drive(1, 4'd3, 0, 0, 1, 4'd0, 0);
    tick(); chk_wr("t5f.c0b", 1, 4'd0, 0);
    chk("t5f.stall", 32'(bus.stall_o), 1);
    drive(0, 0, 0, 0, 1, 4'd9, 1);
    tick(); chk_wr("t5f.clr9", 1, 4'd9, 0);
    chk("t5f.stall0", 32'(bus.stall_o), 0);
    idle();
    tick(); chk_wr("t5f.idle", 0, 0, 0);
    tick(); chk_wr("t5f.idle2", 0, 0, 0);
    chk("t5f.ovf", 32'(bus.overflow_o), 0);

    // Fill under constant clears, overflow, then FIFO drain.
    drive(1, 4'd1, 1, 4'd2, 1, 4'd15, 0);
    tick(); chk_wr("t4.c1", 1, 4'd15, 0);
    chk("t4.stallA", 32'(bus.stall_o), 0);
    drive(1, 4'd3, 1, 4'd4, 1, 4'd15, 0);
    tick(); chk_wr("t4.c2", 1, 4'd15, 0);
    chk("t4.stallB", 32'(bus.stall_o), 1);
    chk("t4.ovfB", 32'(bus.overflow_o), 0);
    drive(1, 4'd5, 1, 4'd6, 1, 4'd15, 0);
    tick(); chk_wr("t4.c3", 1, 4'd15, 0);
    chk("t4.ovfC", 32'(bus.overflow_o), 1);
    idle();
    tick(); chk_wr("t4.d1", 1, 4'd1, 1);
    chk("t4.stall_d1", 32'(bus.stall_o), 1);
    tick(); chk_wr("t4.d2", 1, 4'd2, 1);
    chk("t4.stall_d2", 32'(bus.stall_o), 0);
    tick(); chk_wr("t4.d3", 1, 4'd3, 1);
    tick(); chk_wr("t4.d4", 1, 4'd4, 1);
    tick(); chk_wr("t4.idle", 0, 0, 0);
    chk("t4.ovf_sticky", 32'(bus.overflow_o), 1);

    // Reset between edges during a drain.
    drive(1, 4'd1, 1, 4'd2, 0, 0, 0);
    tick(); chk_wr("t6.w1", 1, 4'd1, 1);
    idle();
    #2 reset = 1'b0;
    #1;
    chk("t6.we", 32'(bus.we0_o), 0);
    chk("t6.addr", 32'(bus.addr0wr_o), 0);
    chk("t6.data", 32'(bus.data0wr_o), 0);
    chk("t6.stall", 32'(bus.stall_o), 0);
    chk("t6.ovf", 32'(bus.overflow_o), 0);
    #1 reset = 1'b1;
    drive(1, 4'd11, 0, 0, 0, 0, 0);
    tick(); chk_wr("t6.w11", 1, 4'd11, 1);
    idle();
    tick(); chk_wr("t6.idle", 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alvio_write_arbiter.md
Name: alvio_write_arbiter

Overview:
- Upstream feeder for the active-list violation RAM's single write port.
- Collects violation reports from two LSU sources per cycle and allocation-clear requests from dispatch.
- Buffers and coalesces the reports in a small queue, then serialises everything onto one write (addr, data, we) per cycle.
- Drives that RAM's addr0wr/data0wr/we0 inputs directly and back-pressures the LSU when the queue is nearly full.

Parameters:
- INDEX, 4, active-list ID width (AL depth = 2^INDEX).
- QDEPTH, 4, pending-report queue entries; must be >= 2.
- QDEPTH_LOG, 2, log2(QDEPTH).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset; asserting it (low) clears all state immediately.
- vioValid0_i  in  1  violation report, source 0 (older priority).
- vioAlId0_i  in  INDEX  AL ID for source 0.
- vioValid1_i  in  1  violation report, source 1.
- vioAlId1_i  in  INDEX  AL ID for source 1.
- alClrValid_i  in  1  dispatch allocated an AL entry; its violation bit must be cleared.
- alClrId_i  in  INDEX  AL ID being allocated.
- flush_i  in  1  pipeline recovery; discard every pending report.
- addr0wr_o  out  INDEX  RAM write address (registered).
- data0wr_o  out  1  RAM write data: 1 = set violation, 0 = clear (registered).
- we0_o  out  1  RAM write enable (registered).
- stall_o  out  1  LSU must not present new reports.
- overflow_o  out  1  sticky error: a report was dropped for lack of space.

Behaviour:
- Reset (low, async): we0_o=0, addr0wr_o=0, data0wr_o=0, stall_o=0, overflow_o=0. All queue valids are 0 and count=0. State holds until reset is released.
- Queue: circular FIFO of QDEPTH {valid, id} entries with head/tail pointers and count. Pointers wrap modulo QDEPTH.
- Output register load, evaluated for cycle N and visible in cycle N+1. Priority order:
  - (a) alClrValid_i → {we=1, addr=alClrId_i, data=0}.
  - (b) else oldest valid queued entry → {1, id, 1}; pop it.
  - (c) else incoming source 0, then source 1, bypassing the queue → {1, id, 1}. The other source, if any, is enqueued.
  - (d) else we0_o=0. addr/data hold their last value.
- Latency: a report or clear presented in cycle N with an empty queue and no competing clear is written in cycle N+1.
- Invalid head entries (killed by a clear) are popped the same cycle without a write. Selection then proceeds to the next entry or the bypass path, which must be resolved combinationally over the queue.
- Coalescing: an incoming report is dropped if any of these holds:
  - its id equals a valid queued id;
  - its id equals the id selected for write this cycle;
  - it is source 1 and its id equals a valid source-0 id in the same cycle.
- Clear interaction:
  - All valid queued entries whose id == alClrId_i are invalidated in the same cycle.
  - An incoming report whose id == alClrId_i is dropped.
- Enqueue order: source 0 before source 1. Up to 2 enqueues plus 1 pop per cycle; count updates accordingly.
- stall_o = (count_next >= QDEPTH-1), registered, so space for two reports is guaranteed when stall_o is low.
- Overflow: reports arriving while the queue has no free slot are dropped and overflow_o is set to 1. It clears only on reset.
- flush_i:
  - Invalidates all entries; count, head and tail go to 0.
  - Incoming reports that cycle are dropped, and no set-write is selected.
  - A simultaneous clear is still written.
  - stall_o=0 next cycle.
- Reset asserted mid-drain: writes stop immediately (we0_o=0). Pending reports are lost.

Test Plan:
1. Report id 5 on source 0 in cycle 2, queue idle → cycle 3: we0_o=1, addr0wr_o=5, data0wr_o=1; cycle 4: we0_o=0.
2. Source 0 and source 1 both report id 7 in one cycle → exactly one write (addr 7, data 1); count stays 0.
3. Source 0 id 3, source 1 id 9, clear id 12 in cycle N → N+1: write 12/0; N+2: write 3/1; N+3: write 9/1; N+4: we0_o=0.
4. Hold clear every cycle and report two distinct ids per cycle → stall_o=1 once count>=3. Keep driving → overflow_o=1; after clears stop, exactly QDEPTH sets drain in FIFO order.
5. Queue ids {4,6}, clear id 4 → write 4/0, then 6/1 only; no write of 4/1 ever. Separately, flush_i with 3 pending → no set writes follow, stall_o=0.
6. Drive reset low between clock edges during a drain → all outputs 0 immediately. After release, the first report is written one cycle after it is presented.
